// File: rtl/subtraction_pkg.sv
// Shared types and constants for the background-subtraction frame scheduler.
package subtraction_pkg;

    localparam int C_LANE_W = 8;
    localparam int C_WORD_W = 24;
    localparam int C_LANES  = C_WORD_W / C_LANE_W;

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } sched_state_t;

    // Packed words needed to carry one row of 'width' pixels.
    function automatic int calc_words(input int width);
        return (width + C_LANES - 1) / C_LANES;
    endfunction

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == C_CNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to re-time live syncs and per-word flags
// to the background buffer read latency.
module sync_delay_line #(
    parameter int P_WIDTH = 1,
    parameter int P_DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [P_WIDTH-1:0] sig,
    output logic [P_WIDTH-1:0] sig_dly
);

    logic [P_WIDTH-1:0] stage [P_DEPTH];

    // Shift one stage per clock; every stage clears on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= sig;
            for (int i = 1; i < P_DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign sig_dly = stage[P_DEPTH-1];

endmodule

// File: rtl/subtraction_frame_sched_ctrl.sv
// Frame scheduler for the background-subtraction path: decides per frame
// whether subtraction runs, strobes background reads, tracks row/word
// position, flags the short last word of a row and reports geometry errors.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | between frames, waiting for the live frame-valid to rise
//   S_FRAME | inside a live frame, counting words/rows, strobing reads
module subtraction_frame_sched_ctrl
    import subtraction_pkg::*;
#(
    parameter int P_IMAGE_WIDTH  = 256,
    parameter int P_IMAGE_HEIGHT = 256,
    parameter int P_RD_LAT       = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_h_aync,
    input  logic        i_v_aync,
    input  logic        i_bg_ready,
    output logic        o_bg_frame_start,
    output logic        o_bg_rd_en,
    output logic        o_h_aync,
    output logic        o_v_aync,
    output logic        o_sub_en,
    output logic        o_remainder_signal,
    output logic [1:0]  o_remainder_cnt,
    output logic [15:0] o_row_cnt,
    output logic [15:0] o_col_cnt,
    output logic        o_err
);

    localparam int          P_WORDS    = calc_words(P_IMAGE_WIDTH);
    localparam int          C_REM      = P_IMAGE_WIDTH % C_LANES;
    localparam int          C_DLY      = 1 + P_RD_LAT;
    localparam bit          C_HAS_REM  = (C_REM != 0);
    localparam logic [1:0]  C_REM2     = 2'(C_REM);
    localparam logic [15:0] C_WORDS16  = 16'(P_WORDS);
    localparam logic [15:0] C_LAST_COL = 16'(P_WORDS - 1);
    localparam logic [15:0] C_HEIGHT16 = 16'(P_IMAGE_HEIGHT);

    sched_state_t state;
    logic         h_q;
    logic         v_q;
    logic         sub_mode;
    logic         tall_seen;
    logic [15:0]  row_cnt;
    logic [15:0]  col_cnt;
    logic         frame_start_r;
    logic         rd_en_r;
    logic         err_r;

    logic         v_rise;
    logic         v_fall;
    logic         h_rise;
    logic         h_fall;
    logic         in_frame;
    logic         last_word;
    logic [1:0]   rem_cnt_now;
    logic         sub_now;
    logic [15:0]  rows_done;
    logic [2:0]   sync_dly;
    logic [2:0]   rem_dly;

    // Single input register stage; all edges are taken against it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            h_q <= i_h_aync;
            v_q <= i_v_aync;
        end
    end

    assign v_rise   = i_v_aync & ~v_q;
    assign v_fall   = ~i_v_aync & v_q;
    assign h_rise   = i_h_aync & ~h_q;
    assign h_fall   = ~i_h_aync & h_q;
    assign in_frame = (state == S_FRAME);

    // A row that ends in the same cycle the frame ends still counts as done.
    assign rows_done = h_fall ? sat_inc16(row_cnt) : row_cnt;

    assign last_word   = in_frame & i_h_aync & (col_cnt == C_LAST_COL) & C_HAS_REM;
    assign rem_cnt_now = last_word ? C_REM2 : 2'd0;

    // Mode of the frame currently on the live syncs; at the opening edge the
    // latched mode is not yet visible, so take it straight from i_bg_ready.
    assign sub_now = in_frame ? (sub_mode & i_v_aync) : (v_rise & i_bg_ready);

    // Frame sequencing, position counters, read strobe and error pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            sub_mode      <= 1'b0;
            tall_seen     <= 1'b0;
            row_cnt       <= '0;
            col_cnt       <= '0;
            frame_start_r <= 1'b0;
            rd_en_r       <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            rd_en_r       <= 1'b0;
            err_r         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (v_rise) begin
                        sub_mode      <= i_bg_ready;
                        frame_start_r <= i_bg_ready;
                        row_cnt       <= '0;
                        col_cnt       <= '0;
                        tall_seen     <= 1'b0;
                        state         <= S_FRAME;
                    end else if (h_rise) begin
                        err_r <= 1'b1;
                    end
                end
                S_FRAME: begin
                    rd_en_r <= i_v_aync & i_h_aync & sub_mode & (row_cnt < C_HEIGHT16);
                    if (v_fall) begin
                        err_r     <= i_h_aync
                                   | (rows_done != C_HEIGHT16)
                                   | (h_fall & (col_cnt != C_WORDS16));
                        row_cnt   <= '0;
                        col_cnt   <= '0;
                        tall_seen <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        if (h_rise && (row_cnt >= C_HEIGHT16) && !tall_seen) begin
                            err_r     <= 1'b1;
                            tall_seen <= 1'b1;
                        end
                        if (h_fall) begin
                            if (col_cnt != C_WORDS16) begin
                                err_r <= 1'b1;
                            end
                            col_cnt <= '0;
                            row_cnt <= sat_inc16(row_cnt);
                        end else if (i_h_aync) begin
                            col_cnt <= sat_inc16(col_cnt);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sync_delay_line #(
        .P_WIDTH (3),
        .P_DEPTH (C_DLY)
    ) u_sync_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .sig     ({sub_now, i_v_aync, i_h_aync}),
        .sig_dly (sync_dly)
    );

    sync_delay_line #(
        .P_WIDTH (3),
        .P_DEPTH (C_DLY)
    ) u_rem_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .sig     ({rem_cnt_now, last_word}),
        .sig_dly (rem_dly)
    );

    assign o_bg_frame_start   = frame_start_r;
    assign o_bg_rd_en         = rd_en_r;
    assign o_err              = err_r;
    assign o_row_cnt          = row_cnt;
    assign o_col_cnt          = col_cnt;
    assign o_h_aync           = sync_dly[0];
    assign o_v_aync           = sync_dly[1];
    assign o_sub_en           = sync_dly[2];
    assign o_remainder_signal = rem_dly[0];
    assign o_remainder_cnt    = rem_dly[2:1];

endmodule

// File: tb/tb_subtraction_frame_sched_ctrl.sv
// Bench for subtraction_frame_sched_ctrl: three instances (W=256/255/257,
// H=4, read latency 1/2/3) share one randomized live stream and are compared
// every cycle against a frame-level reference model, plus per-frame totals.
module tb_subtraction_frame_sched_ctrl;

    localparam int N    = 3;
    localparam int H    = 4;
    localparam int HIST = 16384;

    logic i_clk;
    logic i_rst_n;
    logic i_h_aync;
    logic i_v_aync;
    logic i_bg_ready;

    logic        fs  [N];
    logic        rd  [N];
    logic        oh  [N];
    logic        ov  [N];
    logic        sub [N];
    logic        rs  [N];
    logic        err [N];
    logic [1:0]  rc  [N];
    logic [15:0] row [N];
    logic [15:0] col [N];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit        m_in   [N];
    bit        m_mode [N];
    bit        m_tall [N];
    int        m_row  [N];
    int        m_col  [N];
    bit        m_ph;
    bit        m_pv;
    int        m_n;
    logic [5:0] hist [N][HIST];

    // per-frame totals
    int st_fs [N];
    int st_rd [N];
    int st_err[N];
    int st_rem[N];
    int st_rc1[N];
    int st_rc2[N];
    int st_sub[N];
    int st_ov [N];

    subtraction_frame_sched_ctrl #(.P_IMAGE_WIDTH(256), .P_IMAGE_HEIGHT(H), .P_RD_LAT(1)) dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_h_aync(i_h_aync), .i_v_aync(i_v_aync),
        .i_bg_ready(i_bg_ready), .o_bg_frame_start(fs[0]), .o_bg_rd_en(rd[0]),
        .o_h_aync(oh[0]), .o_v_aync(ov[0]), .o_sub_en(sub[0]), .o_remainder_signal(rs[0]),
        .o_remainder_cnt(rc[0]), .o_row_cnt(row[0]), .o_col_cnt(col[0]), .o_err(err[0]));

    subtraction_frame_sched_ctrl #(.P_IMAGE_WIDTH(255), .P_IMAGE_HEIGHT(H), .P_RD_LAT(2)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_h_aync(i_h_aync), .i_v_aync(i_v_aync),
        .i_bg_ready(i_bg_ready), .o_bg_frame_start(fs[1]), .o_bg_rd_en(rd[1]),
        .o_h_aync(oh[1]), .o_v_aync(ov[1]), .o_sub_en(sub[1]), .o_remainder_signal(rs[1]),
        .o_remainder_cnt(rc[1]), .o_row_cnt(row[1]), .o_col_cnt(col[1]), .o_err(err[1]));

    subtraction_frame_sched_ctrl #(.P_IMAGE_WIDTH(257), .P_IMAGE_HEIGHT(H), .P_RD_LAT(3)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_h_aync(i_h_aync), .i_v_aync(i_v_aync),
        .i_bg_ready(i_bg_ready), .o_bg_frame_start(fs[2]), .o_bg_rd_en(rd[2]),
        .o_h_aync(oh[2]), .o_v_aync(ov[2]), .o_sub_en(sub[2]), .o_remainder_signal(rs[2]),
        .o_remainder_cnt(rc[2]), .o_row_cnt(row[2]), .o_col_cnt(col[2]), .o_err(err[2]));

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int width_of(input int k);
        case (k)
            0:       return 256;
            1:       return 255;
            default: return 257;
        endcase
    endfunction

    function automatic int lat_of(input int k);
        return k + 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_in[k]   = 1'b0;
            m_mode[k] = 1'b0;
            m_tall[k] = 1'b0;
            m_row[k]  = 0;
            m_col[k]  = 0;
        end
        m_ph = 1'b0;
        m_pv = 1'b0;
        m_n  = 0;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < N; k++) begin
            st_fs[k] = 0;  st_rd[k] = 0;  st_err[k] = 0; st_rem[k] = 0;
            st_rc1[k] = 0; st_rc2[k] = 0; st_sub[k] = 0; st_ov[k] = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("%s_fs%0d", tag, k),  fs[k],  0);
            check_eq($sformatf("%s_rd%0d", tag, k),  rd[k],  0);
            check_eq($sformatf("%s_oh%0d", tag, k),  oh[k],  0);
            check_eq($sformatf("%s_ov%0d", tag, k),  ov[k],  0);
            check_eq($sformatf("%s_sub%0d", tag, k), sub[k], 0);
            check_eq($sformatf("%s_rs%0d", tag, k),  rs[k],  0);
            check_eq($sformatf("%s_rc%0d", tag, k),  rc[k],  0);
            check_eq($sformatf("%s_row%0d", tag, k), row[k], 0);
            check_eq($sformatf("%s_col%0d", tag, k), col[k], 0);
            check_eq($sformatf("%s_err%0d", tag, k), err[k], 0);
        end
    endtask

    // One clock: let the DUTs capture the current inputs, then compare every
    // output against the model's view of the frame.
    task automatic tick();
        @(posedge i_clk);
        #1;
        for (int k = 0; k < N; k++) begin
            int         words;
            int         remv;
            int         d;
            int         rows_done;
            bit         vr, vf, hr, hf;
            bit         e_fs, e_rd, e_err, rem_now, sub_now;
            logic [5:0] ent;
            logic [5:0] e_dly;
            words   = (width_of(k) + 2) / 3;
            remv    = width_of(k) % 3;
            d       = 1 + lat_of(k);
            vr      = i_v_aync && !m_pv;
            vf      = !i_v_aync && m_pv;
            hr      = i_h_aync && !m_ph;
            hf      = !i_h_aync && m_ph;
            e_fs    = 1'b0;
            e_rd    = 1'b0;
            e_err   = 1'b0;
            rem_now = 1'b0;
            sub_now = 1'b0;
            if (!m_in[k]) begin
                if (vr) begin
                    m_mode[k] = i_bg_ready;
                    e_fs      = i_bg_ready;
                    sub_now   = i_bg_ready;
                    m_row[k]  = 0;
                    m_col[k]  = 0;
                    m_tall[k] = 1'b0;
                    m_in[k]   = 1'b1;
                end else if (hr) begin
                    e_err = 1'b1;
                end
            end else begin
                sub_now = i_v_aync && m_mode[k];
                rem_now = i_h_aync && (remv != 0) && (m_col[k] == words - 1);
                e_rd    = i_v_aync && i_h_aync && m_mode[k] && (m_row[k] < H);
                if (vf) begin
                    rows_done = m_row[k] + (hf ? 1 : 0);
                    e_err     = i_h_aync || (rows_done != H) || (hf && (m_col[k] != words));
                    m_row[k]  = 0;
                    m_col[k]  = 0;
                    m_tall[k] = 1'b0;
                    m_in[k]   = 1'b0;
                end else begin
                    if (hr && (m_row[k] >= H) && !m_tall[k]) begin
                        e_err     = 1'b1;
                        m_tall[k] = 1'b1;
                    end
                    if (hf) begin
                        if (m_col[k] != words) e_err = 1'b1;
                        m_col[k] = 0;
                        if (m_row[k] < 65535) m_row[k]++;
                    end else if (i_h_aync && (m_col[k] < 65535)) begin
                        m_col[k]++;
                    end
                end
            end
            ent = {sub_now, i_v_aync, i_h_aync, rem_now, (rem_now ? 2'(remv) : 2'd0)};
            hist[k][m_n % HIST] = ent;
            e_dly = (m_n >= d - 1) ? hist[k][(m_n - d + 1) % HIST] : 6'd0;

            check_eq($sformatf("frame_start%0d", k), fs[k],  e_fs);
            check_eq($sformatf("rd_en%0d", k),       rd[k],  e_rd);
            check_eq($sformatf("err%0d", k),         err[k], e_err);
            check_eq($sformatf("row%0d", k),         row[k], m_row[k]);
            check_eq($sformatf("col%0d", k),         col[k], m_col[k]);
            check_eq($sformatf("sub_en%0d", k),      sub[k], e_dly[5]);
            check_eq($sformatf("v_dly%0d", k),       ov[k],  e_dly[4]);
            check_eq($sformatf("h_dly%0d", k),       oh[k],  e_dly[3]);
            check_eq($sformatf("rem_sig%0d", k),     rs[k],  e_dly[2]);
            check_eq($sformatf("rem_cnt%0d", k),     rc[k],  e_dly[1:0]);

            st_fs[k]  += int'(fs[k]);
            st_rd[k]  += int'(rd[k]);
            st_err[k] += int'(err[k]);
            st_rem[k] += int'(rs[k]);
            st_rc1[k] += (rc[k] == 2'd1) ? 1 : 0;
            st_rc2[k] += (rc[k] == 2'd2) ? 1 : 0;
            st_sub[k] += int'(sub[k]);
            st_ov[k]  += int'(ov[k]);
        end
        m_ph = i_h_aync;
        m_pv = i_v_aync;
        m_n++;
    endtask

    // Rows of a frame whose v is already high; optionally a short row, a
    // mid-frame readiness flip, or an abort (v drops while h is high).
    task automatic frame_body(input int rows, input int words, input int short_row,
                              input int short_len, input bit flip, input int abort_len);
        int n;
        bit last;
        for (int r = 0; r < rows; r++) begin
            n    = (r == short_row) ? short_len : words;
            last = (abort_len > 0) && (r == rows - 1);
            if (last) n = abort_len;
            if (flip && r == 1) i_bg_ready = ~i_bg_ready;
            for (int w = 0; w < n; w++) begin
                i_h_aync = 1'b1;
                tick();
            end
            if (last) begin
                i_v_aync = 1'b0;
                tick();
                i_h_aync = 1'b0;
                repeat ($urandom_range(6, 9)) tick();
                return;
            end
            i_h_aync = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
        end
        i_v_aync = 1'b0;
        repeat ($urandom_range(6, 9)) tick();
    endtask

    task automatic send_frame(input int rows, input int words, input bit rdy, input bit flip,
                              input int short_row, input int short_len, input int abort_len);
        i_bg_ready = rdy;
        i_v_aync   = 1'b1;
        repeat ($urandom_range(2, 5)) tick();
        frame_body(rows, words, short_row, short_len, flip, abort_len);
    endtask

    initial begin
        int cyc;
        int words;
        i_rst_n    = 1'b0;
        i_h_aync   = 1'b0;
        i_v_aync   = 1'b0;
        i_bg_ready = 1'b0;
        model_reset();
        #2;
        check_all_zero("reset");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) tick();

        // ready frame, 86-word rows
        clear_stats();
        send_frame(4, 86, 1'b1, 1'b0, -1, 0, 0);
        check_eq("ready_fs_cnt",   st_fs[0],  1);
        check_eq("ready_rd_cnt",   st_rd[0],  344);
        check_eq("ready_err_cnt",  st_err[0], 0);
        check_eq("ready_rem_cnt",  st_rem[0], 4);
        check_eq("ready_rc1_cnt",  st_rc1[0], 4);
        check_eq("ready_sub_vs_v", st_sub[0], st_ov[0]);
        check_eq("w257_rc2_cnt",   st_rc2[2], 4);
        check_eq("w255_err_cnt",   st_err[1], 4);

        // not ready at frame start, ready raised mid-frame
        clear_stats();
        send_frame(4, 86, 1'b0, 1'b1, -1, 0, 0);
        check_eq("notready_rd_cnt",  st_rd[0],  0);
        check_eq("notready_sub_cnt", st_sub[0], 0);
        check_eq("notready_fs_cnt",  st_fs[0],  0);
        clear_stats();
        send_frame(4, 86, 1'b1, 1'b0, -1, 0, 0);
        check_eq("next_rd_cnt", st_rd[0], 344);
        check_eq("next_fs_cnt", st_fs[0], 1);

        // 85-word rows: exact for W=255
        clear_stats();
        send_frame(4, 85, 1'b1, 1'b0, -1, 0, 0);
        check_eq("w255_ok_err", st_err[1], 0);
        check_eq("w255_ok_rd",  st_rd[1],  340);
        check_eq("w256_85_err", st_err[0], 4);

        // short row
        clear_stats();
        send_frame(4, 86, 1'b1, 1'b0, 1, 80, 0);
        check_eq("short_err_cnt", st_err[0], 1);
        check_eq("short_rd_cnt",  st_rd[0],  338);

        // tall frame
        clear_stats();
        send_frame(5, 86, 1'b1, 1'b0, -1, 0, 0);
        check_eq("tall_err_cnt", st_err[0], 2);
        check_eq("tall_rd_cnt",  st_rd[0],  344);

        // frame aborted mid-row
        clear_stats();
        send_frame(3, 86, 1'b1, 1'b0, -1, 0, 30);
        check_eq("abort_err_cnt", st_err[0], 1);

        // h activity with no frame
        clear_stats();
        i_h_aync = 1'b1;
        repeat (3) tick();
        i_h_aync = 1'b0;
        repeat (3) tick();
        check_eq("idle_h_err_cnt", st_err[0], 1);

        // reset mid-row
        i_bg_ready = 1'b1;
        i_v_aync   = 1'b1;
        repeat (3) tick();
        i_h_aync = 1'b1;
        repeat (40) tick();
        #3;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("midrow_rst");
        i_h_aync = 1'b0;
        i_v_aync = 1'b0;
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // delayed-sync latency for read latency 2, then a clean frame
        clear_stats();
        i_bg_ready = 1'b1;
        i_v_aync   = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            tick();
            cyc++;
            if (ov[1] === 1'b1) break;
        end
        check_eq("lat2_v_delay", cyc, 3);
        check_eq("restart_row", row[1], 0);
        check_eq("restart_col", col[1], 0);
        frame_body(4, 85, -1, 0, 1'b0, 0);
        check_eq("restart_err", st_err[1], 0);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            case ($urandom_range(0, 2))
                0:       words = 85;
                1:       words = 86;
                default: words = $urandom_range(60, 90);
            endcase
            send_frame($urandom_range(1, 5), words, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), -1, 0,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 50) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
